// File: rtl/fetch_redirect_unit_if.sv
// Instruction-fetch request bus: address/valid from the fetch unit, ready from memory.
interface fetch_redirect_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] fetch_addr;
  logic                  fetch_valid;
  logic                  fetch_ready;

  modport master (output fetch_addr, output fetch_valid, input fetch_ready);
  modport slave  (input fetch_addr, input fetch_valid, output fetch_ready);
endinterface

// File: rtl/fetch_redirect_unit.sv
// Program counter owner: issues fetch requests, resolves EX-stage jumps/branches,
// and raises flush / stale-fetch kill / misalignment indications.
module fetch_redirect_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  ex_valid,
  input  logic                  ex_branch,
  input  logic                  ex_jal,
  input  logic                  ex_jalr,
  input  logic                  branch_result,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] ex_rs1,
  fetch_redirect_unit_if.master fetch,
  output logic                  flush,
  output logic                  fetch_kill,
  output logic                  misalign,
  output logic [DATA_WIDTH-1:0] misalign_addr
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pend;
  logic                  req_active;

  logic [DATA_WIDTH-1:0] target;
  logic                  take;
  logic                  redirect;
  logic                  misaligned;
  logic                  accepted;

  // JALR has highest priority; JAL and branches share the PC-relative target.
  always_comb begin
    target = ex_pc + ex_imm;
    if (ex_jalr) begin
      target = (ex_rs1 + ex_imm) & {{(DATA_WIDTH-1){1'b1}}, 1'b0};
    end
  end

  // Decisions are ignored in BOOT so flush stays low while held in reset.
  assign take       = (state != BOOT) & ex_valid & (ex_jalr | ex_jal | (ex_branch & branch_result));
  assign redirect   = take & ~target[1];
  assign misaligned = take & target[1];
  assign flush      = redirect;

  always_comb begin
    fetch.fetch_valid = 1'b0;
    case (state)
      RUN:     fetch.fetch_valid = ~stall | req_active;
      HOLD:    fetch.fetch_valid = 1'b1;
      default: fetch.fetch_valid = 1'b0;
    endcase
  end

  assign fetch.fetch_addr = pc;
  assign accepted         = fetch.fetch_valid & fetch.fetch_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      pend          <= '0;
      req_active    <= 1'b0;
      fetch_kill    <= 1'b0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      req_active <= fetch.fetch_valid & ~fetch.fetch_ready;
      fetch_kill <= 1'b0;
      misalign   <= misaligned;
      if (misaligned) begin
        misalign_addr <= target;
      end
      case (state)
        BOOT: begin
          state <= RUN;
          pc    <= RESET_PC;
        end
        RUN: begin
          if (redirect) begin
            if (accepted) begin
              pc         <= target;
              fetch_kill <= 1'b1;
            end else if (fetch.fetch_valid) begin
              // The presented address must stay stable; park the target.
              pend  <= target;
              state <= HOLD;
            end else begin
              pc <= target;
            end
          end else if (accepted) begin
            pc <= pc + DATA_WIDTH'(4);
          end
        end
        HOLD: begin
          if (accepted) begin
            pc         <= redirect ? target : pend;
            fetch_kill <= 1'b1;
            state      <= RUN;
          end else if (redirect) begin
            pend <= target;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
